fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL provide parameter BOOT_DELAY, default 2, the number of cycles ce stays low after reset release (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port stallreq_id, input, 1 bit: decode-stage stall request.
REQ-006 SHALL have port stallreq_ex, input, 1 bit: execute-stage stall request.
REQ-007 SHALL have port branch_flag, input, 1 bit: redirect request from decode.
REQ-008 SHALL have port branch_target, input, 32 bits: redirect address.
REQ-009 SHALL have port rom_ready, input, 1 bit: the instruction ROM has returned data for the current pc.
REQ-010 SHALL have port pc, output, 32 bits: instruction fetch address (registered).
REQ-011 SHALL have port ce, output, 1 bit: instruction ROM enable (registered).
REQ-012 SHALL have port stall, output, 6 bits: per-stage hold vector, bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-013 SHALL have port if_valid, output, 1 bit: the IF/ID register captures a valid instruction this cycle.
REQ-014 SHALL have port addr_err, output, 1 bit: sticky flag for a misaligned branch target.

Function
REQ-015 SHALL implement the FSM states BOOT, FETCH and WAIT.
REQ-016 BOOT SHALL hold ce=0, count up to BOOT_DELAY cycles, then go to FETCH with ce=1 and pc=RESET_PC.
REQ-017 In FETCH or WAIT, a fetch SHALL be accepted when ce=1 AND rom_ready=1 AND stall[0]=0.
REQ-018 On an accepted fetch, pc SHALL update at the next edge: to the pending or current redirect target if one exists, else to pc+4.
REQ-019 The pc+4 addition SHALL be modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
REQ-020 When ce=1, rom_ready=0 and there is no EX/ID stall, the FSM SHALL go to (or stay in) WAIT, hold pc, and drive stall=6'b000011.
REQ-021 In WAIT, rom_ready=1 SHALL return the FSM to FETCH with the accepted-fetch update of REQ-018 applied.
REQ-022 The stall vector SHALL be combinational, with priority stallreq_ex (6'b001111) > stallreq_id (6'b000111) > ROM wait (6'b000011) > 6'b000000.
REQ-023 In BOOT, the stall vector SHALL be 6'b000000.
REQ-024 branch_flag SHALL be ignored while stallreq_ex=1, because decode re-presents it.
REQ-025 branch_flag with stallreq_ex=0 SHALL be recorded into a pending-redirect register (target and valid) if no fetch is accepted that cycle.
REQ-026 The pending redirect SHALL be consumed on the next accepted fetch.
REQ-027 A newer branch_flag SHALL overwrite an older pending redirect.
REQ-028 If branch_flag=1 and a fetch is accepted in the same cycle, branch_target SHALL be used directly and the pending register SHALL be cleared.
REQ-029 A redirect target SHALL have bits[1:0] forced to 0 when loaded into pc.
REQ-030 A redirect target with bits[1:0] != 0 SHALL set addr_err=1 at the next edge, and addr_err SHALL stay 1 until reset.
REQ-031 if_valid SHALL equal (accepted fetch) AND NOT (branch_flag OR pending redirect valid), so the wrong-path instruction is squashed.
REQ-032 ce SHALL never drop to 0 outside reset and BOOT.

Reset
REQ-033 With rst=0 at a rising edge, the next state SHALL be: FSM=BOOT, boot counter=0, pc=RESET_PC, ce=0, pending redirect cleared, addr_err=0.
REQ-034 While in reset, stall=6'b000000 and if_valid=0.
REQ-035 Reset asserted mid-WAIT or with a redirect pending SHALL discard all in-flight state, and no pc update SHALL occur on that edge.
REQ-036 Reset SHALL have priority over every other input.

Verification
REQ-037 Reset release with rom_ready=1, BOOT_DELAY=2 -> ce=0 for 2 cycles, then ce=1 with pc sequence 0x0, 0x4, 0x8, and if_valid=1 each cycle.
REQ-038 rom_ready=0 for 3 cycles at pc=0x8 -> stall=6'b000011 for 3 cycles, pc held at 0x8, then pc=0xC one cycle after rom_ready=1.
REQ-039 branch_flag=1, target=0x100, during a ROM wait at pc=0x20 -> pc=0x100 after rom_ready returns, and if_valid=0 on that accept.
REQ-040 stallreq_ex=1 with stallreq_id=1 and branch_flag=1 -> stall=6'b001111, pc unchanged, branch ignored.
REQ-041 Set RESET_PC=32'hFFFFFFF8 and run 3 fetches -> pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
REQ-042 branch_target=0x103 -> pc=0x100, addr_err=1 persisting until rst=0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-controller handshake bundle: pipeline stall requests, redirect and ROM
// ready in; fetch address, ROM enable, stall vector and status out.
interface fetch_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ready;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        if_valid;
  logic        addr_err;

  modport master (
    input  stallreq_id, stallreq_ex, branch_flag, branch_target, rom_ready,
    output pc, ce, stall, if_valid, addr_err
  );

  modport slave (
    output stallreq_id, stallreq_ex, branch_flag, branch_target, rom_ready,
    input  pc, ce, stall, if_valid, addr_err
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: boot delay, PC sequencing, ROM wait handling,
// pending-redirect capture and the per-stage pipeline stall vector.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned BOOT_DELAY = 2
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StBoot, StFetch, StWait} state_e;

  localparam logic [3:0] BootLast = 4'(BOOT_DELAY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        err_q, err_d;

  logic        accept;
  logic        br_live;
  logic        rom_wait;
  logic [31:0] br_aligned;
  logic [5:0]  stall_vec;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    ce_d         = ce_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    err_d        = err_q;
    stall_vec    = 6'b000000;
    accept       = 1'b0;
    rom_wait     = 1'b0;
    // Decode re-presents a branch held up by an EX stall, so drop it here.
    br_live      = bus.branch_flag & ~bus.stallreq_ex;
    br_aligned   = {bus.branch_target[31:2], 2'b00};

    unique case (state_q)
      StBoot: begin
        if (cnt_q == BootLast) begin
          state_d = StFetch;
          ce_d    = 1'b1;
          pc_d    = RESET_PC;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StFetch, StWait: begin
        rom_wait = ce_q & ~bus.rom_ready;
        if (bus.stallreq_ex)      stall_vec = 6'b001111;
        else if (bus.stallreq_id) stall_vec = 6'b000111;
        else if (rom_wait)        stall_vec = 6'b000011;

        accept = ce_q & bus.rom_ready & ~stall_vec[0];
        if (accept) begin
          state_d      = StFetch;
          pend_valid_d = 1'b0;
          if (br_live)           pc_d = br_aligned;
          else if (pend_valid_q) pc_d = pend_tgt_q;
          else                   pc_d = pc_q + 32'd4;
        end else begin
          if (br_live) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = br_aligned;
          end
          if (rom_wait && !bus.stallreq_ex && !bus.stallreq_id) state_d = StWait;
        end

        if (br_live && (bus.branch_target[1:0] != 2'b00)) err_d = 1'b1;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StBoot;
      cnt_q        <= 4'd0;
      pc_q         <= RESET_PC;
      ce_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= 32'h0000_0000;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
      err_q        <= err_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign bus.stall    = rst ? stall_vec : 6'b000000;
  assign bus.if_valid = rst & accept & ~(bus.branch_flag | pend_valid_q);
  assign bus.pc       = pc_q;
  assign bus.ce       = ce_q;
  assign bus.addr_err = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic compared against a cycle-level behavioural model.
module tb_fetch_ctrl;

  localparam int unsigned BootDelay = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   nstep  = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if bus ();
  fetch_ctrl_if bus2 ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .BOOT_DELAY(BootDelay)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .BOOT_DELAY(BootDelay)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Reference model state
  logic [31:0] m_pc;
  logic        m_ce;
  int          m_boot;
  logic        m_pv;
  logic [31:0] m_pt;
  logic        m_err;

  logic [5:0]  obs_stall;
  logic        obs_ifv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (step %0d): observed %h expected %h", tag, nstep, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0000_0000;
    m_ce   = 1'b0;
    m_boot = 0;
    m_pv   = 1'b0;
    m_pt   = 32'h0;
    m_err  = 1'b0;
  endtask

  // Apply one cycle of inputs, compare at the falling edge, advance the model.
  task automatic step(input logic r, input logic ex, input logic id, input logic br,
                      input logic [31:0] tgt, input logic rdy);
    logic [5:0]  e_stall;
    logic        e_ifv;
    logic        acc;
    logic        brv;
    rst               = r;
    bus.stallreq_ex   = ex;
    bus.stallreq_id   = id;
    bus.branch_flag   = br;
    bus.branch_target = tgt;
    bus.rom_ready     = rdy;
    nstep++;
    @(negedge clk);
    if (!r || !m_ce) e_stall = 6'd0;
    else if (ex)     e_stall = 6'd15;
    else if (id)     e_stall = 6'd7;
    else if (!rdy)   e_stall = 6'd3;
    else             e_stall = 6'd0;
    acc   = r && m_ce && rdy && !ex && !id;
    e_ifv = acc && !br && !m_pv;
    check("pc", bus.pc, m_pc);
    check("ce", 32'(bus.ce), 32'(m_ce));
    check("stall", 32'(bus.stall), 32'(e_stall));
    check("if_valid", 32'(bus.if_valid), 32'(e_ifv));
    check("addr_err", 32'(bus.addr_err), 32'(m_err));
    obs_stall = bus.stall;
    obs_ifv   = bus.if_valid;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (!m_ce) begin
      m_boot++;
      if (m_boot >= int'(BootDelay)) m_ce = 1'b1;
    end else begin
      brv = br && !ex;
      if (acc) begin
        if (brv)       m_pc = tgt & ~32'd3;
        else if (m_pv) m_pc = m_pt;
        else           m_pc = m_pc + 32'd4;
        m_pv = 1'b0;
      end else if (brv) begin
        m_pv = 1'b1;
        m_pt = tgt & ~32'd3;
      end
      if (brv && tgt[1:0] != 2'b00) m_err = 1'b1;
    end
    #1;
  endtask

  task automatic go(input logic rdy);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    logic        r, ex, id, br, rdy;
    logic [31:0] tgt;

    rst                = 1'b0;
    bus.stallreq_ex    = 1'b0;
    bus.stallreq_id    = 1'b0;
    bus.branch_flag    = 1'b0;
    bus.branch_target  = 32'h0;
    bus.rom_ready      = 1'b1;
    bus2.stallreq_ex   = 1'b0;
    bus2.stallreq_id   = 1'b0;
    bus2.branch_flag   = 1'b0;
    bus2.branch_target = 32'h0;
    bus2.rom_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_pc2", bus2.pc, 32'hFFFF_FFF8);

    // Boot then three sequential fetches
    go(1'b1);
    check("boot_ce_low", 32'(bus.ce), 32'd0);
    go(1'b1);
    check("boot_ce_high", 32'(bus.ce), 32'd1);
    check("boot_pc", bus.pc, 32'h0);
    check("wrap_pc0", bus2.pc, 32'hFFFF_FFF8);
    go(1'b1);
    check("seq_ifv0", 32'(obs_ifv), 32'd1);
    check("seq_pc4", bus.pc, 32'h4);
    check("wrap_pc1", bus2.pc, 32'hFFFF_FFFC);
    go(1'b1);
    check("seq_ifv1", 32'(obs_ifv), 32'd1);
    check("seq_pc8", bus.pc, 32'h8);
    check("wrap_pc2", bus2.pc, 32'h0);
    check("wrap_no_err", 32'(bus2.addr_err), 32'd0);

    // ROM wait for three cycles at 0x8
    for (int i = 0; i < 3; i++) begin
      go(1'b0);
      check("wait_stall", 32'(obs_stall), 32'h03);
      check("wait_pc", bus.pc, 32'h8);
    end
    go(1'b1);
    check("wait_resume_pc", bus.pc, 32'hC);

    // Redirect captured during a ROM wait at 0x20
    repeat (5) go(1'b1);
    check("pc_20", bus.pc, 32'h20);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    go(1'b0);
    go(1'b1);
    check("pend_squash", 32'(obs_ifv), 32'd0);
    check("pend_pc", bus.pc, 32'h100);

    // EX stall masks a branch
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
    check("ex_stall", 32'(obs_stall), 32'h0F);
    check("ex_pc_hold", bus.pc, 32'h100);
    go(1'b1);
    check("ex_br_ignored", bus.pc, 32'h104);

    // Misaligned target: aligned pc and sticky error
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 1'b1);
    check("mis_pc", bus.pc, 32'h100);
    check("mis_err", 32'(bus.addr_err), 32'd1);
    repeat (3) go(1'b1);
    check("mis_err_sticky", 32'(bus.addr_err), 32'd1);

    // Reset mid-wait with a redirect pending
    go(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_ce", 32'(bus.ce), 32'd0);
    check("rst_err", 32'(bus.addr_err), 32'd0);
    repeat (3) go(1'b1);
    check("rst_no_redirect", bus.pc, 32'h4);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 49) != 0);
      ex  = ($urandom_range(0, 9) == 0);
      id  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      step(r, ex, id, br, tgt, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
